// File: rtl/ram_stream_reader.sv
// Streams a (base, count) block out of the B port of a dual-port RAM as valid/ready words.
// Reads are issued only when the 2-entry output buffer is guaranteed to have room for them.
module ram_stream_reader #(
    parameter int DEPTH = 10,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DEPTH-1:0] base,
    input  logic [DEPTH:0]   count,
    output logic [DEPTH-1:0] ram_address,
    output logic             ram_oe,
    output logic             ram_we,
    output logic [WIDTH-1:0] ram_din,
    input  logic [WIDTH-1:0] ram_dout,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [DEPTH-1:0] ADDR_ONE = {{(DEPTH-1){1'b0}}, 1'b1};
    localparam logic [DEPTH:0]   CNT_ONE  = {{DEPTH{1'b0}}, 1'b1};

    state_t           state_reg, state_next;
    logic [DEPTH-1:0] addr_reg;
    logic [DEPTH:0]   issue_cnt_reg;
    logic [DEPTH:0]   count_reg;
    logic [DEPTH:0]   pop_cnt_reg;
    logic             rd_valid_reg;
    logic [1:0]       fill_reg;
    logic             wr_ptr_reg, rd_ptr_reg;
    logic [WIDTH-1:0] entry_data [2];
    logic             push, pop, issue;
    logic [2:0]       level_after_pop;

    assign push    = rd_valid_reg;
    assign pop     = m_valid & m_ready;
    assign m_valid = (fill_reg != 2'd0);
    assign m_data  = entry_data[rd_ptr_reg];
    assign m_last  = m_valid && ((pop_cnt_reg + CNT_ONE) == count_reg);

    // Words that will occupy the buffer once this cycle's push and pop settle; a read
    // issued now lands there two edges later, so it only fits if this is below 2.
    assign level_after_pop = {1'b0, fill_reg} + {2'b00, rd_valid_reg} - {2'b00, pop};
    assign issue = (state_reg == RUN) && (issue_cnt_reg != '0) && (level_after_pop < 3'd2);

    assign ram_address = addr_reg;
    assign ram_we      = 1'b0;
    assign ram_din     = '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = (count == '0) ? DONE : RUN;
            RUN:     if (issue && (issue_cnt_reg == CNT_ONE)) state_next = DRAIN;
            DRAIN:   if (pop && m_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ram_oe depends on this cycle's pop so a returning m_ready reissues without a bubble.
    always_comb begin
        ram_oe = issue;
        busy   = (state_reg != IDLE);
        done   = (state_reg == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg      <= '0;
            issue_cnt_reg <= '0;
            count_reg     <= '0;
            pop_cnt_reg   <= '0;
            rd_valid_reg  <= 1'b0;
        end else begin
            rd_valid_reg <= issue;
            if (state_reg == IDLE && start) begin
                addr_reg      <= base;
                issue_cnt_reg <= count;
                count_reg     <= count;
                pop_cnt_reg   <= '0;
            end else begin
                if (issue) begin
                    addr_reg      <= addr_reg + ADDR_ONE;
                    issue_cnt_reg <= issue_cnt_reg - CNT_ONE;
                end
                if (pop) begin
                    pop_cnt_reg <= pop_cnt_reg + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_reg   <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            fill_reg <= fill_reg + {1'b0, push} - {1'b0, pop};
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [WIDTH-1:0] data_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    data_reg <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    data_reg <= ram_dout;
                end
            end
            assign entry_data[gi] = data_reg;
        end
    endgenerate

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader against a 16-word RAM model holding mem[i] = i + 100.
// A negedge monitor logs handshakes, reads, done pulses and tracks buffer occupancy.
module tb_ram_stream_reader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  base;
    logic [4:0]  count;
    logic [3:0]  ram_address;
    logic        ram_oe;
    logic        ram_we;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    logic mon_en = 1'b0;

    logic [31:0] mem [16];
    logic [31:0] hs_data [$];
    logic        hs_last [$];
    int          hs_cyc [$];
    logic [3:0]  oe_addr [$];
    int          done_cyc [$];
    logic        busy_log [64];

    ram_stream_reader #(.DEPTH(4), .WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .base(base), .count(count),
        .ram_address(ram_address), .ram_oe(ram_oe), .ram_we(ram_we), .ram_din(ram_din),
        .ram_dout(ram_dout), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'(i + 100);
    end

    always @(posedge clk) begin
        if (ram_oe) ram_dout <= mem[ram_address];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int k, input int mode);
        if (mode == 0) return 1'b1;
        return ((k % 4) == 0) || ((k % 4) == 3);
    endfunction

    initial begin : monitor
        int rel;
        int occ;
        int pend;
        int pop_i;
        occ = 0;
        pend = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                rel = cyc - t0;
                pop_i = (m_valid && m_ready) ? 1 : 0;
                check("m_valid", 32'(m_valid), 32'(occ != 0));
                if (occ + pend - pop_i >= 2) check("oe_while_full", 32'(ram_oe), 32'd0);
                if (ram_oe) begin
                    check("ram_we", 32'(ram_we), 32'd0);
                    check("ram_din", ram_din, 32'd0);
                    oe_addr.push_back(ram_address);
                end
                if (pop_i == 1) begin
                    hs_data.push_back(m_data);
                    hs_last.push_back(m_last);
                    hs_cyc.push_back(rel);
                end
                if (done) done_cyc.push_back(rel);
                if (rel >= 0 && rel < 64) busy_log[rel] = busy;
                occ = occ + pend - pop_i;
                pend = ram_oe ? 1 : 0;
                check("occupancy_le_2", 32'(occ <= 2), 32'd1);
                if (reset) begin
                    occ = 0;
                    pend = 0;
                end
            end
        end
    end

    task automatic clear_logs();
        hs_data.delete();
        hs_last.delete();
        hs_cyc.delete();
        oe_addr.delete();
        done_cyc.delete();
        for (int i = 0; i < 64; i++) busy_log[i] = 1'bx;
    endtask

    // One request starting in relative cycle 0; an optional second start (base 0, count 3) at restart_at.
    task automatic run_req(input int b, input int c, input int mode, input int restart_at);
        clear_logs();
        @(posedge clk); #1;
        t0 = cyc;
        base = b[3:0];
        count = c[4:0];
        start = 1'b1;
        m_ready = rdy(0, mode);
        for (int k = 1; k < 45; k++) begin
            @(posedge clk); #1;
            start = (k == restart_at);
            if (k == restart_at) begin
                base = 4'd0;
                count = 5'd3;
            end
            m_ready = rdy(k, mode);
        end
        start = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic expect_stream(input string name, input int b, input int c,
                                 input int first_cyc, input int done_at);
        check({name, "_words"}, hs_data.size(), c);
        check({name, "_reads"}, oe_addr.size(), c);
        for (int i = 0; i < c && i < hs_data.size(); i++) begin
            check({name, "_data"}, hs_data[i], 32'(100 + ((b + i) % 16)));
            check({name, "_last"}, 32'(hs_last[i]), 32'(i == c - 1));
            if (first_cyc >= 0) check({name, "_hs_cycle"}, hs_cyc[i], first_cyc + i);
        end
        for (int i = 0; i < c && i < oe_addr.size(); i++) begin
            check({name, "_addr"}, 32'(oe_addr[i]), 32'((b + i) % 16));
        end
        check({name, "_done_pulses"}, done_cyc.size(), 1);
        if (done_at >= 0 && done_cyc.size() > 0) check({name, "_done_cycle"}, done_cyc[0], done_at);
        $display("req %s base=%0d count=%0d words=%0d done_at=%0d", name, b, c, hs_data.size(),
                 (done_cyc.size() > 0) ? done_cyc[0] : -1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        base = '0;
        count = '0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ram_oe", 32'(ram_oe), 32'd0);
        check("rst_ram_address", 32'(ram_address), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_data", m_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_din", ram_din, 32'd0);
        mon_en = 1'b1;

        // Continuous stream; a start in the done cycle (8) must be ignored.
        run_req(4, 5, 0, 8);
        expect_stream("cont", 4, 5, 3, 8);
        check("cont_busy_c0", 32'(busy_log[0]), 32'd0);
        check("cont_busy_c1", 32'(busy_log[1]), 32'd1);
        check("cont_busy_c8", 32'(busy_log[8]), 32'd1);
        check("cont_busy_c9", 32'(busy_log[9]), 32'd0);

        run_req(14, 4, 0, -1);
        expect_stream("wrap", 14, 4, 3, 7);

        run_req(0, 8, 1, -1);
        expect_stream("backpressure", 0, 8, -1, -1);

        run_req(3, 0, 0, -1);
        check("zero_done_pulses", done_cyc.size(), 1);
        if (done_cyc.size() > 0) check("zero_done_cycle", done_cyc[0], 1);
        check("zero_reads", oe_addr.size(), 0);
        check("zero_words", hs_data.size(), 0);
        check("zero_busy_c1", 32'(busy_log[1]), 32'd1);
        check("zero_busy_c2", 32'(busy_log[2]), 32'd0);
        $display("req zero base=3 count=0 words=%0d done_pulses=%0d", hs_data.size(), done_cyc.size());

        // Reset asserted in cycle 5 of a 10-word request.
        clear_logs();
        @(posedge clk); #1;
        t0 = cyc;
        base = 4'd2;
        count = 5'd10;
        start = 1'b1;
        m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_ram_oe", 32'(ram_oe), 32'd0);
        check("abort_ram_address", 32'(ram_address), 32'd0);
        check("abort_m_valid", 32'(m_valid), 32'd0);
        check("abort_m_last", 32'(m_last), 32'd0);
        check("abort_m_data", m_data, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (15) @(posedge clk);
        check("abort_no_done", done_cyc.size(), 0);
        $display("req abort base=2 count=10 words_before_reset=%0d done_pulses=%0d",
                 hs_data.size(), done_cyc.size());

        run_req(2, 3, 0, -1);
        expect_stream("after_reset", 2, 3, 3, 6);

        // Whole memory, with a second start pulsed mid-request.
        run_req(5, 16, 0, 6);
        expect_stream("full", 5, 16, 3, 19);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
